ahb_m2s_mux_n: RTL and testbench
================================

// Module: ahb_m2s_mux_n
// PURPOSE
//   Parametrised AHB-Lite master-to-slave mux for an N-master matrix port. Routes the
//   granted master's address/control in the address phase. Internally pipelines the
//   select into the data phase, gated by HREADY, to route HWDATA.
//   Exports the data-phase owner so the s2m response path routes HRDATA/HRESP/HREADYOUT.
//   Sits between the per-slave arbiter and the slave port.
// PARAMETERS
//   NUM_MASTERS  4   number of master ports (>=2)
//   ADDR_W       32  HADDR width
//   DATA_W       32  HWDATA width
//   SEL_W        $clog2(NUM_MASTERS)  localparam, select width
// PORTS
//   HCLK            in   1                   bus clock
//   HRESETn         in   1                   async reset, active low
//   Master_Sel_A    in   SEL_W               address-phase master select from arbiter
//   Master_Grant_A  in   1                   arbiter has a valid grant this cycle
//   HREADY          in   1                   slave-side HREADY (transfer completion)
//   M_HADDR         in   NUM_MASTERS*ADDR_W  flattened; master i at [i*ADDR_W +: ADDR_W]
//   M_HBURST        in   NUM_MASTERS*3       flattened per master
//   M_HMASTLOCK     in   NUM_MASTERS         bit i = master i
//   M_HPROT         in   NUM_MASTERS*4       flattened per master
//   M_HSIZE         in   NUM_MASTERS*3       flattened per master
//   M_HTRANS        in   NUM_MASTERS*2       flattened per master
//   M_HWRITE        in   NUM_MASTERS         bit i = master i
//   M_HWDATA        in   NUM_MASTERS*DATA_W  flattened per master
//   HADDR/HBURST/HMASTLOCK/HPROT/HSIZE/HTRANS/HWRITE  out  ADDR_W/3/1/4/3/2/1  slave addr/ctrl
//   HWDATA          out  DATA_W              slave write data
//   Master_Sel_D    out  SEL_W               data-phase owner (registered)
//   Data_Valid_D    out  1                   data phase holds an active (NONSEQ/SEQ) transfer
// BEHAVIOUR
//   Address phase (combinational, 0 latency):
//   - addr_ok = Master_Grant_A && (Master_Sel_A < NUM_MASTERS).
//   - addr_ok=1: all address/control outputs = fields of master Master_Sel_A.
//   - addr_ok=0: HTRANS=2'b00 (IDLE); HADDR, HBURST, HPROT, HSIZE, HWRITE, HMASTLOCK = 0.
//   Data-phase register (posedge HCLK, async clear on HRESETn=0):
//   - HREADY=1: Master_Sel_D <= Master_Sel_A (or 0 if !addr_ok).
//   - HREADY=1: Data_Valid_D <= addr_ok && HTRANS[1].
//   - HREADY=0: both hold (wait-stated data phase keeps owner).
//   - Reset values: Master_Sel_D=0, Data_Valid_D=0.
//   HWDATA (combinational from registered select):
//   - = master Master_Sel_D's HWDATA when Data_Valid_D=1, else 0.
//   - Reads also forward write data; slaves ignore it.
//   Boundary cases:
//   - Out-of-range select: treated as no grant; IDLE driven, never X.
//   - Select change while HREADY=0: address outputs follow immediately (arbiter must hold);
//     data-phase owner unchanged.
//   - BUSY (2'b01) or IDLE accepted: Data_Valid_D=0, so HWDATA=0 next phase.
//   - Handover: new master's address phase and old master's data phase overlap in one
//     cycle; each path uses its own select.
//   - Reset mid-transfer: data-phase state clears immediately.
//   - HWDATA=0 and address outputs = IDLE for combinational inputs with Master_Grant_A=0.
//   - No latches; all case/default paths assigned; NUM_MASTERS need not be a power of 2.
// TESTING
//   1. Reset: HRESETn=0 -> Master_Sel_D=0, Data_Valid_D=0, HWDATA=0, HTRANS=IDLE with grant=0.
//   2. Grant M2 NONSEQ write HADDR=0x2000_0040, HREADY=1:
//      - same cycle HADDR=0x2000_0040, HWRITE=1;
//      - next cycle Master_Sel_D=2, HWDATA=M2 data 0xDEADBEEF.
//   3. Wait states: same as 2, HREADY=0 for 3 cycles while Sel_A->1:
//      - HWDATA stays M2's 0xDEADBEEF;
//      - after HREADY=1, Master_Sel_D=1.
//   4. NUM_MASTERS=3, Sel_A=3, grant=1 -> HTRANS=IDLE, HADDR=0; next cycle Data_Valid_D=0.
//   5. Back-to-back M0 SEQ burst then M3 NONSEQ, HREADY=1 -> handover cycle: HADDR from M3,
//      HWDATA from M0.
//   6. Async reset asserted mid data phase (Data_Valid_D=1) -> outputs cleared before next edge.

Source files
------------

// File: rtl/ahb_m2s_mux_n.sv
// AHB-Lite master-to-slave mux for one slave port of an N-master matrix.
// Address/control is routed combinationally; HWDATA follows the registered data-phase owner.
module ahb_m2s_mux_n #(
  parameter  int NUM_MASTERS = 4,
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  localparam int SEL_W       = $clog2(NUM_MASTERS)
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [SEL_W-1:0]              Master_Sel_A,
  input  logic                          Master_Grant_A,
  input  logic                          HREADY,
  input  logic [NUM_MASTERS*ADDR_W-1:0] M_HADDR,
  input  logic [NUM_MASTERS*3-1:0]      M_HBURST,
  input  logic [NUM_MASTERS-1:0]        M_HMASTLOCK,
  input  logic [NUM_MASTERS*4-1:0]      M_HPROT,
  input  logic [NUM_MASTERS*3-1:0]      M_HSIZE,
  input  logic [NUM_MASTERS*2-1:0]      M_HTRANS,
  input  logic [NUM_MASTERS-1:0]        M_HWRITE,
  input  logic [NUM_MASTERS*DATA_W-1:0] M_HWDATA,
  output logic [ADDR_W-1:0]             HADDR,
  output logic [2:0]                    HBURST,
  output logic                          HMASTLOCK,
  output logic [3:0]                    HPROT,
  output logic [2:0]                    HSIZE,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [DATA_W-1:0]             HWDATA,
  output logic [SEL_W-1:0]              Master_Sel_D,
  output logic                          Data_Valid_D
);

  localparam logic [SEL_W:0] NUM_M_C = (SEL_W+1)'(NUM_MASTERS);

  logic             w_addr_ok;
  logic [SEL_W-1:0] r_sel_d;
  logic             r_vld_d;

  // Select beyond NUM_MASTERS is only reachable when NUM_MASTERS is not a power of 2.
  assign w_addr_ok = Master_Grant_A && ({1'b0, Master_Sel_A} < NUM_M_C);

  // AND-OR style mux: no out-of-range indexing, so an illegal select yields IDLE/zeros.
  always_comb begin
    HADDR     = '0;
    HBURST    = '0;
    HMASTLOCK = 1'b0;
    HPROT     = '0;
    HSIZE     = '0;
    HTRANS    = 2'b00;
    HWRITE    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_addr_ok && (Master_Sel_A == SEL_W'(i))) begin
        HADDR     = M_HADDR[i*ADDR_W +: ADDR_W];
        HBURST    = M_HBURST[i*3 +: 3];
        HMASTLOCK = M_HMASTLOCK[i];
        HPROT     = M_HPROT[i*4 +: 4];
        HSIZE     = M_HSIZE[i*3 +: 3];
        HTRANS    = M_HTRANS[i*2 +: 2];
        HWRITE    = M_HWRITE[i];
      end
    end
  end

  // Data-phase owner advances only when the current transfer completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel_d <= '0;
      r_vld_d <= 1'b0;
    end else if (HREADY) begin
      r_sel_d <= w_addr_ok ? Master_Sel_A : '0;
      r_vld_d <= w_addr_ok && HTRANS[1];
    end
  end

  always_comb begin
    HWDATA = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_vld_d && (r_sel_d == SEL_W'(i)))
        HWDATA = M_HWDATA[i*DATA_W +: DATA_W];
    end
  end

  assign Master_Sel_D = r_sel_d;
  assign Data_Valid_D = r_vld_d;

endmodule

// File: tb/tb_ahb_m2s_mux_n.sv
// Directed bench for ahb_m2s_mux_n: a 4-master instance plus a 3-master instance
// to reach the out-of-range select.
module tb_ahb_m2s_mux_n;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic HREADY;

  // 4-master instance
  logic [1:0]        sel4;
  logic              gnt4;
  logic [3:0][31:0]  m_haddr, m_hwdata;
  logic [3:0][2:0]   m_hburst, m_hsize;
  logic [3:0][3:0]   m_hprot;
  logic [3:0][1:0]   m_htrans;
  logic [3:0]        m_hlock, m_hwrite;
  logic [31:0]       haddr4, hwdata4;
  logic [2:0]        hburst4, hsize4;
  logic [3:0]        hprot4;
  logic [1:0]        htrans4, seld4;
  logic              hlock4, hwrite4, vld4;

  // 3-master instance
  logic [1:0]        sel3;
  logic              gnt3;
  logic [2:0][31:0]  n_haddr, n_hwdata;
  logic [2:0][2:0]   n_hburst, n_hsize;
  logic [2:0][3:0]   n_hprot;
  logic [2:0][1:0]   n_htrans;
  logic [2:0]        n_hlock, n_hwrite;
  logic [31:0]       haddr3, hwdata3;
  logic [2:0]        hburst3, hsize3;
  logic [3:0]        hprot3;
  logic [1:0]        htrans3, seld3;
  logic              hlock3, hwrite3, vld3;

  int n_vec = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  ahb_m2s_mux_n #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .Master_Sel_A(sel4), .Master_Grant_A(gnt4), .HREADY(HREADY),
    .M_HADDR(m_haddr), .M_HBURST(m_hburst), .M_HMASTLOCK(m_hlock), .M_HPROT(m_hprot),
    .M_HSIZE(m_hsize), .M_HTRANS(m_htrans), .M_HWRITE(m_hwrite), .M_HWDATA(m_hwdata),
    .HADDR(haddr4), .HBURST(hburst4), .HMASTLOCK(hlock4), .HPROT(hprot4),
    .HSIZE(hsize4), .HTRANS(htrans4), .HWRITE(hwrite4), .HWDATA(hwdata4),
    .Master_Sel_D(seld4), .Data_Valid_D(vld4)
  );

  ahb_m2s_mux_n #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32)) u_dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .Master_Sel_A(sel3), .Master_Grant_A(gnt3), .HREADY(HREADY),
    .M_HADDR(n_haddr), .M_HBURST(n_hburst), .M_HMASTLOCK(n_hlock), .M_HPROT(n_hprot),
    .M_HSIZE(n_hsize), .M_HTRANS(n_htrans), .M_HWRITE(n_hwrite), .M_HWDATA(n_hwdata),
    .HADDR(haddr3), .HBURST(hburst3), .HMASTLOCK(hlock3), .HPROT(hprot3),
    .HSIZE(hsize3), .HTRANS(htrans3), .HWRITE(hwrite3), .HWDATA(hwdata3),
    .Master_Sel_D(seld3), .Data_Valid_D(vld3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_m(input int i, input logic [31:0] a, input logic [1:0] t,
                       input logic w, input logic [31:0] d);
    m_haddr[i]  = a;
    m_htrans[i] = t;
    m_hwrite[i] = w;
    m_hwdata[i] = d;
    m_hburst[i] = 3'(i + 1);
    m_hsize[i]  = 3'b010;
    m_hprot[i]  = 4'(i + 8);
    m_hlock[i]  = i[0];
  endtask

  initial begin
    HRESETn = 1'b0;
    HREADY  = 1'b1;
    sel4 = 2'd0; gnt4 = 1'b0;
    sel3 = 2'd0; gnt3 = 1'b0;
    n_haddr = '0; n_hwdata = '0; n_hburst = '0; n_hsize = '0;
    n_hprot = '0; n_htrans = '0; n_hlock = '0; n_hwrite = '0;
    set_m(0, 32'h0000_0100, 2'b11, 1'b1, 32'hA0A0_A0A0);
    set_m(1, 32'h1000_0010, 2'b10, 1'b1, 32'h1111_1111);
    set_m(2, 32'h2000_0040, 2'b10, 1'b1, 32'hDEAD_BEEF);
    set_m(3, 32'h3000_0000, 2'b10, 1'b0, 32'h3333_3333);

    // Reset state, no grant: IDLE and zeros even though masters drive traffic
    #3;
    chk("rst_seld",   64'(seld4),   64'd0);
    chk("rst_vld",    64'(vld4),    64'd0);
    chk("rst_hwdata", 64'(hwdata4), 64'd0);
    chk("rst_htrans", 64'(htrans4), 64'd0);
    chk("rst_haddr",  64'(haddr4),  64'd0);
    HRESETn = 1'b1;

    // Grant M2 NONSEQ write
    sel4 = 2'd2; gnt4 = 1'b1;
    #1;
    chk("t2_haddr",  64'(haddr4),  64'h2000_0040);
    chk("t2_hwrite", 64'(hwrite4), 64'd1);
    chk("t2_htrans", 64'(htrans4), 64'd2);
    chk("t2_hburst", 64'(hburst4), 64'd3);
    chk("t2_hprot",  64'(hprot4),  64'd10);
    chk("t2_hsize",  64'(hsize4),  64'd2);
    chk("t2_hlock",  64'(hlock4),  64'd0);
    tick();
    gnt4 = 1'b0;
    #1;
    chk("t2_seld",   64'(seld4),   64'd2);
    chk("t2_vld",    64'(vld4),    64'd1);
    chk("t2_hwdata", 64'(hwdata4), 64'hDEAD_BEEF);
    chk("t2_idle",   64'(htrans4), 64'd0);
    tick();
    chk("t2_vld_off", 64'(vld4),    64'd0);
    chk("t2_wd_off",  64'(hwdata4), 64'd0);
    chk("t2_seld0",   64'(seld4),   64'd0);

    // Wait states: owner held while the address phase already shows M1
    sel4 = 2'd2; gnt4 = 1'b1;
    tick();
    HREADY = 1'b0; sel4 = 2'd1;
    #1;
    chk("t3_haddr_m1", 64'(haddr4), 64'h1000_0010);
    chk("t3_hlock_m1", 64'(hlock4), 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t3_ws%0d_hwdata", c), 64'(hwdata4), 64'hDEAD_BEEF);
      chk($sformatf("t3_ws%0d_seld", c),   64'(seld4),   64'd2);
    end
    HREADY = 1'b1;
    tick();
    chk("t3_seld",   64'(seld4),   64'd1);
    chk("t3_vld",    64'(vld4),    64'd1);
    chk("t3_hwdata", 64'(hwdata4), 64'h1111_1111);

    // Handover M0 SEQ -> M3 NONSEQ
    sel4 = 2'd0;
    tick();
    sel4 = 2'd3;
    #1;
    chk("t5_haddr_m3",  64'(haddr4),  64'h3000_0000);
    chk("t5_hwrite_m3", 64'(hwrite4), 64'd0);
    chk("t5_hwdata_m0", 64'(hwdata4), 64'hA0A0_A0A0);
    chk("t5_seld_m0",   64'(seld4),   64'd0);
    tick();
    chk("t5_hwdata_m3", 64'(hwdata4), 64'h3333_3333);
    chk("t5_seld_m3",   64'(seld4),   64'd3);
    // BUSY accepted: no data phase
    m_htrans[3] = 2'b01;
    #1;
    chk("busy_htrans", 64'(htrans4), 64'd1);
    tick();
    chk("busy_vld",    64'(vld4),    64'd0);
    chk("busy_hwdata", 64'(hwdata4), 64'd0);
    chk("busy_seld",   64'(seld4),   64'd3);
    m_htrans[3] = 2'b10;
    gnt4 = 1'b0;

    // NUM_MASTERS=3 with out-of-range select
    n_haddr[1] = 32'h1234_5678; n_htrans[1] = 2'b10; n_hwrite[1] = 1'b1;
    n_hwdata[1] = 32'h5555_AAAA; n_hlock[1] = 1'b1;
    sel3 = 2'd1; gnt3 = 1'b1;
    tick();
    chk("t4_pre_vld",  64'(vld3),    64'd1);
    chk("t4_pre_wd",   64'(hwdata3), 64'h5555_AAAA);
    sel3 = 2'd3;
    #1;
    chk("t4_htrans", 64'(htrans3), 64'd0);
    chk("t4_haddr",  64'(haddr3),  64'd0);
    chk("t4_hwrite", 64'(hwrite3), 64'd0);
    chk("t4_hlock",  64'(hlock3),  64'd0);
    tick();
    chk("t4_vld",    64'(vld3),    64'd0);
    chk("t4_seld",   64'(seld3),   64'd0);
    chk("t4_hwdata", 64'(hwdata3), 64'd0);
    gnt3 = 1'b0;

    // Async reset in the middle of an active data phase
    sel4 = 2'd2; gnt4 = 1'b1;
    tick();
    chk("t6_pre_vld", 64'(vld4), 64'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("t6_vld",    64'(vld4),    64'd0);
    chk("t6_seld",   64'(seld4),   64'd0);
    chk("t6_hwdata", 64'(hwdata4), 64'd0);
    #2;
    HRESETn = 1'b1;
    gnt4 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
